// File: rtl/sw_pkg.sv
// Shared types for the DE0 slide-switch debouncer.
//   NUM_SW     : number of slide switches handled (SW0..SW9)
//   sw_vec_t   : one bit per switch
//   hs_state_t : snapshot handshake state (IDLE: no snapshot, PEND: snapshot offered)
//   cnt_width  : stability-counter width for a given DB_CYCLES, never below 1 bit
package sw_pkg;

  localparam int unsigned NUM_SW = 10;

  typedef logic [NUM_SW-1:0] sw_vec_t;

  typedef enum logic {
    IDLE = 1'b0,
    PEND = 1'b1
  } hs_state_t;

  // Enough bits to hold 0..DB_CYCLES; a 1-cycle filter still needs one bit.
  function automatic int unsigned cnt_width(input int unsigned cycles);
    int unsigned w;
    w = $clog2(cycles + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/sw_db_bit.sv
// One switch lane: 2-flop synchroniser, stability counter and debounced flop.
// Ports:
//   clk, n_reset : clock, asynchronous active-low reset
//   raw          : asynchronous switch input
//   db_nxt_c     : debounced value after the coming edge (combinational)
//   chg_c        : debounced value flips on the coming edge (combinational)
// The debounced level changes only after sync has differed from it for
// DB_CYCLES consecutive cycles; the new level is taken on the edge where the
// counter already holds DB_CYCLES-1.
module sw_db_bit
  import sw_pkg::*;
#(
  parameter int unsigned DB_CYCLES = 4
) (
  input  logic clk,
  input  logic n_reset,
  input  logic raw,
  output logic db_nxt_c,
  output logic chg_c
);

  localparam int unsigned CW = cnt_width(DB_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

  logic          sync_1;
  logic          sync_2;
  logic          db;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;

  // Metastability filter; only sync_2 is used downstream.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      sync_1 <= 1'b0;
      sync_2 <= 1'b0;
    end else begin
      sync_1 <= raw;
      sync_2 <= sync_1;
    end
  end

  // Stability count and acceptance of the new level.
  always_comb begin
    cnt_nxt  = '0;
    db_nxt_c = db;
    chg_c    = 1'b0;
    if (sync_2 != db) begin
      if (cnt == CNT_LAST) begin
        db_nxt_c = sync_2;
        chg_c    = 1'b1;
      end else begin
        cnt_nxt = cnt + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      cnt <= '0;
      db  <= 1'b0;
    end else begin
      cnt <= cnt_nxt;
      db  <= db_nxt_c;
    end
  end

endmodule

// File: rtl/sw_debounce.sv
// Debounces the ten DE0 slide switches and offers snapshots of the debounced
// state to a downstream bit-serial stage through a valid/ready handshake.
// Ports:
//   clk, n_reset : clock, asynchronous active-low reset
//   SW           : raw asynchronous switches
//   sw_out       : debounced snapshot, held while sw_valid is high
//   sw_valid     : snapshot offered
//   sw_ready     : downstream accepts (transfer on sw_valid && sw_ready)
//   sw_rise/fall : one-cycle debounced edge pulses, only when SW_EDGE_EN is defined
// Changes that arrive while a snapshot is pending mark it dirty; on transfer a
// dirty snapshot is immediately replaced by the current debounced state so the
// downstream stage always ends up with the latest value.
module sw_debounce
  import sw_pkg::*;
#(
  parameter int unsigned DB_CYCLES = 4
) (
  input  logic    clk,
  input  logic    n_reset,
  input  sw_vec_t SW,
  output sw_vec_t sw_out,
  output logic    sw_valid,
  input  logic    sw_ready
`ifdef SW_EDGE_EN
  ,
  output sw_vec_t sw_rise,
  output sw_vec_t sw_fall
`endif
);

  sw_vec_t   db_nxt;
  sw_vec_t   chg;
  logic      any_chg;

  hs_state_t state;
  hs_state_t state_nxt;
  sw_vec_t   out_nxt;
  logic      valid_nxt;
  logic      dirty;
  logic      dirty_nxt;

  // Per-switch synchroniser and debounce lanes.
  for (genvar i = 0; i < int'(NUM_SW); i++) begin : g_bit
    sw_db_bit #(
      .DB_CYCLES(DB_CYCLES)
    ) u_bit (
      .clk     (clk),
      .n_reset (n_reset),
      .raw     (SW[i]),
      .db_nxt_c(db_nxt[i]),
      .chg_c   (chg[i])
    );
  end

  // Any number of simultaneous bit changes collapses into one snapshot event.
  assign any_chg = |chg;

  // Handshake state register and registered outputs.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state    <= IDLE;
      sw_out   <= '0;
      sw_valid <= 1'b0;
      dirty    <= 1'b0;
    end else begin
      state    <= state_nxt;
      sw_out   <= out_nxt;
      sw_valid <= valid_nxt;
      dirty    <= dirty_nxt;
    end
  end

  // Next-state and output logic; sw_ready is only looked at in PEND.
  always_comb begin
    state_nxt = state;
    out_nxt   = sw_out;
    valid_nxt = sw_valid;
    dirty_nxt = dirty;
    case (state)
      IDLE: begin
        if (any_chg) begin
          out_nxt   = db_nxt;
          valid_nxt = 1'b1;
          dirty_nxt = 1'b0;
          state_nxt = PEND;
        end
      end
      PEND: begin
        if (sw_ready) begin
          if (dirty || any_chg) begin
            out_nxt   = db_nxt;
            dirty_nxt = 1'b0;
          end else begin
            valid_nxt = 1'b0;
            state_nxt = IDLE;
          end
        end else if (any_chg) begin
          dirty_nxt = 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
        valid_nxt = 1'b0;
        dirty_nxt = 1'b0;
      end
    endcase
  end

`ifdef SW_EDGE_EN
  // Edge pulses coincide with the cycle the debounced bit takes its new level.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      sw_rise <= '0;
      sw_fall <= '0;
    end else begin
      sw_rise <= chg & db_nxt;
      sw_fall <= chg & ~db_nxt;
    end
  end
`endif

endmodule

// File: tb/tb_sw_debounce.sv
// Self-checking bench for sw_debounce (DB_CYCLES = 4). A reference model turns
// the sampled switch history into expected outputs, queued per cycle and per
// transfer; a monitor pops and compares against the DUT.
module tb_sw_debounce;
  import sw_pkg::*;

  localparam int unsigned DB = 4;

  typedef struct packed {
    logic    valid;
    sw_vec_t out;
    sw_vec_t rise;
    sw_vec_t fall;
  } exp_t;

  logic    clk = 1'b0;
  logic    n_reset;
  sw_vec_t sw_in;
  logic    sw_ready;
  sw_vec_t sw_out;
  logic    sw_valid;
`ifdef SW_EDGE_EN
  sw_vec_t sw_rise;
  sw_vec_t sw_fall;
`endif

  sw_debounce #(
    .DB_CYCLES(DB)
  ) dut (
    .clk     (clk),
    .n_reset (n_reset),
    .SW      (sw_in),
    .sw_out  (sw_out),
    .sw_valid(sw_valid),
    .sw_ready(sw_ready)
`ifdef SW_EDGE_EN
    ,
    .sw_rise (sw_rise),
    .sw_fall (sw_fall)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  exp_t    exp_q[$];
  sw_vec_t snap_q[$];

  task automatic chk(input string name, input sw_vec_t got, input sw_vec_t want);
    checks++;
    if (got === want) passes++;
    else $display("FAIL %s: got %h expected %h at %0t", name, got, want, $time);
  endtask

  // ---------------- reference model ----------------
  // A switch level is accepted when the DB samples taken 2..DB+1 edges ago
  // all differ from the current debounced level (2 edges of synchroniser).
  sw_vec_t hist[$];
  sw_vec_t m_db, m_out;
  logic    m_valid, m_dirty;

  task automatic model_reset();
    hist.delete();
    for (int j = 0; j < int'(DB) + 1; j++) hist.push_back('0);
    m_db    = '0;
    m_out   = '0;
    m_valid = 1'b0;
    m_dirty = 1'b0;
  endtask

  initial begin
    exp_t    e;
    sw_vec_t chg, nd;
    logic    all_new, xfer;
    forever begin
      @(posedge clk);
      e = '0;
      if (!n_reset) begin
        model_reset();
      end else begin
        chg = '0;
        for (int i = 0; i < int'(NUM_SW); i++) begin
          all_new = 1'b1;
          for (int j = 0; j < int'(DB); j++)
            if (hist[j][i] == m_db[i]) all_new = 1'b0;
          chg[i] = all_new;
        end
        nd   = m_db ^ chg;
        xfer = m_valid && sw_ready;
        if (xfer) snap_q.push_back(m_out);
        if (!m_valid) begin
          if (chg != '0) begin
            m_out   = nd;
            m_valid = 1'b1;
            m_dirty = 1'b0;
          end
        end else if (xfer) begin
          if (m_dirty || chg != '0) begin
            m_out   = nd;
            m_dirty = 1'b0;
          end else begin
            m_valid = 1'b0;
          end
        end else if (chg != '0) begin
          m_dirty = 1'b1;
        end
        e.rise = chg & nd;
        e.fall = chg & ~nd;
        m_db = nd;
        void'(hist.pop_front());
        hist.push_back(sw_in);
      end
      e.valid = m_valid;
      e.out   = m_out;
      exp_q.push_back(e);
    end
  end

  // ---------------- monitor ----------------
  logic    obs_xfer = 1'b0;
  sw_vec_t obs_out  = '0;

  initial begin
    exp_t    e;
    sw_vec_t s;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("sw_valid", NUM_SW'(sw_valid), NUM_SW'(e.valid));
        chk("sw_out", sw_out, e.out);
`ifdef SW_EDGE_EN
        chk("sw_rise", sw_rise, e.rise);
        chk("sw_fall", sw_fall, e.fall);
`endif
      end
      if (obs_xfer) begin
        if (snap_q.size() == 0) begin
          checks++;
          $display("FAIL transfer: got unexpected snapshot %h expected none at %0t", obs_out, $time);
        end else begin
          s = snap_q.pop_front();
          chk("transfer", obs_out, s);
        end
      end
      #3;
      obs_xfer = n_reset && sw_valid && sw_ready;
      obs_out  = sw_out;
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(input sw_vec_t s, input logic r, input int n);
    @(negedge clk);
    #2;
    sw_in    = s;
    sw_ready = r;
    repeat (n - 1) @(negedge clk);
  endtask

  task automatic check_zero(input string name);
    chk({name, "_valid"}, NUM_SW'(sw_valid), '0);
    chk({name, "_out"}, sw_out, '0);
`ifdef SW_EDGE_EN
    chk({name, "_rise"}, sw_rise, '0);
    chk({name, "_fall"}, sw_fall, '0);
`endif
  endtask

  initial begin
    sw_vec_t s;
    n_reset  = 1'b0;
    sw_in    = '0;
    sw_ready = 1'b0;
    repeat (3) @(negedge clk);
    check_zero("reset");
    #2 n_reset = 1'b1;

    // Quiet switches, then a clean change held with no ready.
    drive(10'h000, 1'b0, 20);
    drive(10'h005, 1'b0, 12);
    drive(10'h005, 1'b1, 1);
    drive(10'h005, 1'b0, 3);

    // Return to zero and consume; then a 3-cycle glitch on SW0.
    drive(10'h000, 1'b0, 10);
    drive(10'h000, 1'b1, 1);
    drive(10'h000, 1'b0, 3);
    drive(10'h001, 1'b0, 3);
    drive(10'h000, 1'b0, 10);

    // Change during PEND marks the snapshot dirty.
    drive(10'h005, 1'b0, 10);
    drive(10'h205, 1'b0, 10);
    drive(10'h205, 1'b1, 1);
    drive(10'h205, 1'b0, 3);
    drive(10'h205, 1'b1, 1);
    drive(10'h205, 1'b0, 3);

    // All switches high, reset pulsed while the snapshot is pending.
    drive(10'h3FF, 1'b0, 10);
    @(negedge clk);
    #2 n_reset = 1'b0;
    #1 check_zero("async_reset");
    repeat (2) @(negedge clk);
    #2 n_reset = 1'b1;
    drive(10'h3FF, 1'b0, 10);

    // SW9 pulse with ready held high.
    drive(10'h000, 1'b1, 12);
    drive(10'h200, 1'b1, 10);
    drive(10'h000, 1'b1, 10);

    // Random switch bounce and random ready.
    s = '0;
    repeat (80) begin
      s = s ^ NUM_SW'($urandom_range(0, 1023) & $urandom_range(0, 1023));
      drive(s, 1'($urandom_range(0, 1)), int'($urandom_range(1, 8)));
    end

    // Drain: let everything settle and be consumed.
    drive(s, 1'b1, 15);
    drive(s, 1'b0, 3);
    checks++;
    if (snap_q.size() == 0) passes++;
    else $display("FAIL pending_transfers: got %0d outstanding expected 0", snap_q.size());

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
